bf16_div_seq: RTL and testbench

- Multi-cycle bfloat16 divider on the unit side of op_intf (op_intf.unit_side modport).
- Consumes op1/op2 sign/exp/frac presented by the operand dispatcher and returns op3 plus overflow.
- Adds a start/busy/done handshake so the dispatcher can hold MODE_DIV until the result is valid.
- Computes op1 / op2 with a restoring radix-2 mantissa divider at fixed latency, rounding to nearest-even.

---
 rtl/bf16_div_seq_pkg.sv | 30 +++
 rtl/bf16_div_seq_frac_div_step.sv | 24 ++
 rtl/bf16_div_seq.sv | 204 ++++++++++++++++++++
 tb/tb_bf16_div_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bf16_div_seq_pkg.sv
// Shared types, constants and rounding helper for the sequential bfloat16 divider.
// Imported by the divider top and its restoring-step sub-module.
package bf16_div_seq_pkg;

  localparam int BF16_EXP_W  = 8;
  localparam int BF16_FRAC_W = 7;
  localparam int BF16_BIAS   = 127;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [BF16_EXP_W-1:0] BF16_INF_EXP = 8'hFF;

  typedef struct packed {
    logic                   sign;
    logic [BF16_EXP_W-1:0]  exp;
    logic [BF16_FRAC_W-1:0] frac;
  } bf16_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DIVIDE = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } div_state_e;

  // Round-to-nearest-even increment decision.
  function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
    return guard & (lsb | sticky);
  endfunction

endpackage

// File: rtl/bf16_div_seq_frac_div_step.sv
// One combinational restoring-division step: subtract the divisor when it fits,
// emit the quotient bit and return the doubled partial remainder.
module frac_div_step #(
  parameter int RW = 9,
  parameter int MW = 8
) (
  input  logic [RW-1:0] rem,
  input  logic [MW-1:0] m2,
  output logic [RW-1:0] next_rem,
  output logic          q_bit
);

  logic [RW:0]   trial_s;
  logic [RW-1:0] keep_s;

  // Trial subtraction; the borrow bit decides the quotient digit.
  always_comb begin
    trial_s  = {1'b0, rem} - {{(RW + 1 - MW){1'b0}}, m2};
    q_bit    = ~trial_s[RW];
    keep_s   = q_bit ? trial_s[RW-1:0] : rem;
    next_rem = RW'({keep_s, 1'b0});
  end

endmodule

// File: rtl/bf16_div_seq.sv
// Multi-cycle bfloat16 divider with start/busy/done handshake, restoring radix-2
// mantissa division and round-to-nearest-even at fixed latency for every operand class.
module bf16_div_seq
  import bf16_div_seq_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  op1_sign,
  input  logic [EXP_WIDTH-1:0]  op1_exp,
  input  logic [FRAC_WIDTH-1:0] op1_frac,
  input  logic                  op2_sign,
  input  logic [EXP_WIDTH-1:0]  op2_exp,
  input  logic [FRAC_WIDTH-1:0] op2_frac,
  output logic                  op3_sign,
  output logic [EXP_WIDTH-1:0]  op3_exp,
  output logic [FRAC_WIDTH-1:0] op3_frac,
  output logic                  overflow
);

  localparam int MW = FRAC_WIDTH + 1;
  localparam int RW = FRAC_WIDTH + 2;
  localparam int QW = FRAC_WIDTH + 3;
  localparam int EW = EXP_WIDTH + 2;
  localparam int CW = $clog2(QW);
  localparam logic [EW-1:0] BIAS_E   = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic [EW-1:0] ONES_E   = EW'((1 << EXP_WIDTH) - 1);
  localparam logic [EW-1:0] ONE_E    = EW'(1);
  localparam logic [CW-1:0] LAST_CNT = CW'(QW - 1);

  div_state_e state_r, state_s;
  logic [CW-1:0]         cnt_r;
  logic                  a_sign_r, b_sign_r;
  logic [EXP_WIDTH-1:0]  a_exp_r, b_exp_r;
  logic [FRAC_WIDTH-1:0] a_frac_r, b_frac_r;
  logic                  sign_r, nan_r, dz_r, zero_r;
  logic [EW-1:0]         exp_r;
  logic [MW-1:0]         m2_r;
  logic [RW-1:0]         rem_r;
  logic [QW-1:0]         quo_r;

  logic [RW-1:0]         next_rem_s;
  logic                  q_bit_s;
  logic [FRAC_WIDTH-1:0] fr_s;
  logic                  guard_s, sticky_s;
  logic [FRAC_WIDTH:0]   fr_rnd_s;
  logic [EW-1:0]         e_norm_s, e_fin_s;
  logic                  res_sign_s, res_ovf_s;
  logic [EXP_WIDTH-1:0]  res_exp_s;
  logic [FRAC_WIDTH-1:0] res_frac_s;

  frac_div_step #(.RW(RW), .MW(MW)) u_step (
    .rem      (rem_r),
    .m2       (m2_r),
    .next_rem (next_rem_s),
    .q_bit    (q_bit_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start_i) state_s = LOAD; else state_s = IDLE;
      LOAD:    state_s = DIVIDE;
      DIVIDE:  if (cnt_r == LAST_CNT) state_s = ROUND; else state_s = DIVIDE;
      ROUND:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Normalize, round and resolve special cases from the finished quotient.
  always_comb begin
    fr_s       = '0;
    guard_s    = 1'b0;
    sticky_s   = 1'b0;
    e_norm_s   = exp_r;
    res_sign_s = sign_r;
    res_exp_s  = '0;
    res_frac_s = '0;
    res_ovf_s  = 1'b0;
    // A quotient below 1.0 carries its hidden bit one place lower.
    if (quo_r[QW-1]) begin
      fr_s     = quo_r[QW-2 -: FRAC_WIDTH];
      guard_s  = quo_r[1];
      sticky_s = quo_r[0] | (|rem_r);
      e_norm_s = exp_r;
    end else begin
      fr_s     = quo_r[QW-3 -: FRAC_WIDTH];
      guard_s  = quo_r[0];
      sticky_s = |rem_r;
      e_norm_s = exp_r - ONE_E;
    end
    // Carry out of the fraction means the mantissa rounded up to 2.0.
    fr_rnd_s = {1'b0, fr_s} + {{FRAC_WIDTH{1'b0}}, rne_inc(fr_s[0], guard_s, sticky_s)};
    e_fin_s  = e_norm_s + {{(EW - 1){1'b0}}, fr_rnd_s[FRAC_WIDTH]};
    if (nan_r) begin
      res_sign_s = 1'b0;
      res_exp_s  = '1;
      res_frac_s = FRAC_WIDTH'(1) << (FRAC_WIDTH - 1);
      res_ovf_s  = 1'b1;
    end else if (dz_r) begin
      res_exp_s  = '1;
      res_ovf_s  = 1'b1;
    end else if (zero_r) begin
      res_exp_s  = '0;
      res_ovf_s  = 1'b0;
    end else if (!e_fin_s[EW-1] && (e_fin_s >= ONES_E)) begin
      res_exp_s  = '1;
      res_ovf_s  = 1'b1;
    end else if (e_fin_s[EW-1] || (e_fin_s == '0)) begin
      res_exp_s  = '0;
      res_ovf_s  = 1'b0;
    end else begin
      res_exp_s  = e_fin_s[EXP_WIDTH-1:0];
      res_frac_s = fr_rnd_s[FRAC_WIDTH-1:0];
      res_ovf_s  = 1'b0;
    end
  end

  // Operand capture, iteration datapath and registered results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r    <= '0;
      a_sign_r <= 1'b0;
      b_sign_r <= 1'b0;
      a_exp_r  <= '0;
      b_exp_r  <= '0;
      a_frac_r <= '0;
      b_frac_r <= '0;
      sign_r   <= 1'b0;
      nan_r    <= 1'b0;
      dz_r     <= 1'b0;
      zero_r   <= 1'b0;
      exp_r    <= '0;
      m2_r     <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      op3_sign <= 1'b0;
      op3_exp  <= '0;
      op3_frac <= '0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            a_sign_r <= op1_sign;
            a_exp_r  <= op1_exp;
            a_frac_r <= op1_frac;
            b_sign_r <= op2_sign;
            b_exp_r  <= op2_exp;
            b_frac_r <= op2_frac;
            busy_o   <= 1'b1;
          end
        end
        LOAD: begin
          nan_r  <= (&a_exp_r) | (&b_exp_r);
          dz_r   <= (b_exp_r == '0);
          zero_r <= (a_exp_r == '0);
          sign_r <= a_sign_r ^ b_sign_r;
          exp_r  <= {2'b00, a_exp_r} - {2'b00, b_exp_r} + BIAS_E;
          m2_r   <= {1'b1, b_frac_r};
          rem_r  <= {1'b0, 1'b1, a_frac_r};
          quo_r  <= '0;
          cnt_r  <= '0;
        end
        DIVIDE: begin
          rem_r <= next_rem_s;
          quo_r <= {quo_r[QW-2:0], q_bit_s};
          cnt_r <= (cnt_r == LAST_CNT) ? '0 : cnt_r + CW'(1);
        end
        ROUND: begin
          op3_sign <= res_sign_s;
          op3_exp  <= res_exp_s;
          op3_frac <= res_frac_s;
          overflow <= res_ovf_s;
          done_o   <= 1'b1;
          busy_o   <= 1'b0;
        end
        DONE: begin
          done_o <= 1'b0;
        end
        default: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_div_seq.sv
// Self-checking bench for bf16_div_seq: directed cases, handshake timing, abort by
// reset and randomized operands against an integer-arithmetic bfloat16 division model.
module tb_bf16_div_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       busy_o, done_o;
  logic       op1_sign, op2_sign, op3_sign;
  logic [7:0] op1_exp, op2_exp, op3_exp;
  logic [6:0] op1_frac, op2_frac, op3_frac;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  bf16_div_seq #(.EXP_WIDTH(8), .FRAC_WIDTH(7)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .op1_sign (op1_sign),
    .op1_exp  (op1_exp),
    .op1_frac (op1_frac),
    .op2_sign (op2_sign),
    .op2_exp  (op2_exp),
    .op2_frac (op2_frac),
    .op3_sign (op3_sign),
    .op3_exp  (op3_exp),
    .op3_frac (op3_frac),
    .overflow (overflow)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact quotient of the real values, rounded to nearest-even into bfloat16.
  function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, e, sh, mant;
    logic   s, g, st;
    longint num, den, q;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if (ea == 255 || eb == 255) return {1'b1, 16'h7FC0};
    if (eb == 0) return {1'b1, s, 8'hFF, 7'h00};
    if (ea == 0) return {1'b0, s, 15'h0000};
    num = longint'(128 + int'(a[6:0])) << 16;
    den = longint'(128 + int'(b[6:0]));
    q   = num / den;
    st  = (num % den) != 0;
    e   = ea - eb + 127;
    if (q >= (longint'(1) << 16)) sh = 9;
    else begin
      sh = 8;
      e  = e - 1;
    end
    mant = int'(q >> sh);
    g    = ((q >> (sh - 1)) & 1) != 0;
    st   = st | ((q & ((longint'(1) << (sh - 1)) - 1)) != 0);
    if (g && ((mant % 2) == 1 || st)) mant++;
    if (mant == 256) begin
      mant = 128;
      e++;
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 7'h00};
    if (e <= 0) return {1'b0, s, 15'h0000};
    return {1'b0, s, e[7:0], mant[6:0]};
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 254));
      3:       e = 8'($urandom_range(248, 254));
      4:       e = 8'($urandom_range(1, 6));
      default: e = 8'($urandom_range(110, 144));
    endcase
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  // Launch one division, optionally pulse a stray start at edge inj, then check timing and result.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_res, input logic exp_ovf, input int inj);
    int   lat;
    logic busy_ok;
    lat     = 99;
    busy_ok = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1;
    {op1_sign, op1_exp, op1_frac} = a;
    {op2_sign, op2_exp, op2_frac} = b;
    @(posedge clk_i);
    #1;
    busy_ok &= busy_o;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      if (k == inj) begin
        start_i = 1'b1;
        {op1_sign, op1_exp, op1_frac} = 16'h4400;
        {op2_sign, op2_exp, op2_frac} = 16'h3F00;
      end else begin
        start_i = 1'b0;
        {op1_sign, op1_exp, op1_frac} = 16'($urandom);
        {op2_sign, op2_exp, op2_frac} = 16'($urandom);
      end
      @(posedge clk_i);
      #1;
      if (done_o) begin
        lat = k;
        break;
      end
      busy_ok &= busy_o;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd12);
    chk({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_result"}, {15'd0, overflow, op3_sign, op3_exp, op3_frac}, {15'd0, exp_ovf, exp_res});
    @(posedge clk_i);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_hold"}, {15'd0, overflow, op3_sign, op3_exp, op3_frac}, {15'd0, exp_ovf, exp_res});
  endtask

  initial begin
    logic [15:0] a, b;
    logic [16:0] r;
    logic        seen;
    rst_i    = 1'b1;
    start_i  = 1'b0;
    {op1_sign, op1_exp, op1_frac} = 16'h0000;
    {op2_sign, op2_exp, op2_frac} = 16'h0000;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_state", {13'd0, busy_o, done_o, overflow, op3_sign, op3_exp, op3_frac}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    do_op("one_div_one", 16'h3F80, 16'h3F80, 16'h3F80, 1'b0, 0);
    do_op("three_div_two", 16'h4040, 16'h4000, 16'h3FC0, 1'b0, 0);
    do_op("one_div_three", 16'h3F80, 16'h4040, 16'h3EAB, 1'b0, 0);
    do_op("neg_two_div_two", 16'hC000, 16'h4000, 16'hBF80, 1'b0, 0);
    do_op("pos_div_zero", 16'h4000, 16'h0000, 16'h7F80, 1'b1, 0);
    do_op("neg_div_zero", 16'hC000, 16'h0000, 16'hFF80, 1'b1, 0);
    do_op("zero_div_two", 16'h0000, 16'h4000, 16'h0000, 1'b0, 0);
    do_op("inf_div_one", 16'h7F80, 16'h3F80, 16'h7FC0, 1'b1, 0);
    do_op("exp_overflow", 16'h7F00, 16'h3F00, 16'h7F80, 1'b1, 0);
    do_op("exp_underflow", 16'h0080, 16'h7F00, 16'h0000, 1'b0, 0);
    do_op("stray_start", 16'h4040, 16'h4000, 16'h3FC0, 1'b0, 5);
    do_op("back_to_back", 16'hC000, 16'h4000, 16'hBF80, 1'b0, 0);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk_i);
    start_i = 1'b1;
    {op1_sign, op1_exp, op1_frac} = 16'h4040;
    {op2_sign, op2_exp, op2_frac} = 16'h4000;
    @(posedge clk_i);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      @(posedge clk_i);
    end
    #2;
    rst_i = 1'b1;
    #1;
    chk("abort_outputs", {13'd0, busy_o, done_o, overflow, op3_sign, op3_exp, op3_frac}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk_i);
      #1;
      seen |= done_o;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    do_op("after_abort", 16'h3F80, 16'h4040, 16'h3EAB, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      a = rnd_op();
      b = rnd_op();
      r = ref_div(a, b);
      do_op($sformatf("rand%0d_%h_%h", i, a, b), a, b, r[15:0], r[16], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
